// File: rtl/pipe_adder_pkg.sv
// Shared types for the pipelined adder: op encoding, flag bundle and the
// WIDTH/STAGES legality check used at elaboration.
package adder_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBC = 2'b11
    } op_e;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
        logic negative;
    } flags_t;

    function automatic bit cfg_legal(input int width, input int stages);
        return (stages >= 1) && (stages <= 4) && (width > 0) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipe_adder_cla_group.sv
// Combinational GROUP-bit carry-lookahead slice; also exposes the carry into
// its MSB so the top slice can form signed overflow.
module cla_group #(
    parameter int G = 16
) (
    input  logic [G-1:0] iX,
    input  logic [G-1:0] iY,
    input  logic         iCin,
    output logic [G-1:0] oSum,
    output logic         oCout,
    output logic         oCMsb
);

    logic [G-1:0] w_g;
    logic [G-1:0] w_p;
    logic [G:0]   w_c;

    assign w_g = iX & iY;
    assign w_p = iX | iY;

    always_comb begin
        w_c    = '0;
        w_c[0] = iCin;
        for (int unsigned i = 0; i < G; i++) begin
            w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
        end
    end

    assign oSum  = iX ^ iY ^ w_c[G-1:0];
    assign oCout = w_c[G];
    assign oCMsb = w_c[G-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined ADD/SUB/ADC/SBC: one lookahead group per stage, group carry
// registered stage to stage. Optional signed saturation under PIPE_ADDER_SAT_EN.
module pipe_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iValid,
    output logic             oReady,
    input  logic [1:0]       iOp,
    input  logic [WIDTH-1:0] iX,
    input  logic [WIDTH-1:0] iY,
    input  logic             iCarry,
    input  logic             iSat,
    output logic             oValid,
    input  logic             iReady,
    output logic [WIDTH-1:0] oS,
    output logic             oCarry,
    output logic             oOverflow,
    output logic             oZero,
    output logic             oNegative
);

    localparam int GROUP = WIDTH / STAGES;

    if (!cfg_legal(WIDTH, STAGES)) begin : g_cfg_check
        $error("pipe_adder: STAGES must be 1..4 and divide WIDTH");
    end

    op_e              w_op;
    logic [WIDTH-1:0] w_y_eff;
    logic             w_cin;
    logic             w_adv;

    assign w_op = op_e'(iOp);

    always_comb begin
        w_y_eff = iY;
        w_cin   = 1'b0;
        unique case (w_op)
            OP_ADD: begin w_y_eff = iY;  w_cin = 1'b0;   end
            OP_SUB: begin w_y_eff = ~iY; w_cin = 1'b1;   end
            OP_ADC: begin w_y_eff = iY;  w_cin = iCarry; end
            OP_SBC: begin w_y_eff = ~iY; w_cin = iCarry; end
        endcase
    end

    // Single global advance: the whole pipe shifts or the whole pipe holds.
    assign w_adv  = ~oValid | iReady;
    assign oReady = w_adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             w_v_in, w_c_in, w_sat_in;
        logic [WIDTH-1:0] w_x_in, w_y_in, w_s_in, w_sum, w_s_out;
        logic [GROUP-1:0] w_gsum;
        logic             w_gcout, w_gcmsb;
        logic             r_v, r_c, r_sat;
        logic [WIDTH-1:0] r_x, r_y, r_s;

        if (k == 0) begin : g_in
            assign w_v_in   = iValid;
            assign w_c_in   = w_cin;
            assign w_sat_in = iSat;
            assign w_x_in   = iX;
            assign w_y_in   = w_y_eff;
            assign w_s_in   = '0;
        end else begin : g_in
            assign w_v_in   = g_stage[k-1].r_v;
            assign w_c_in   = g_stage[k-1].r_c;
            assign w_sat_in = g_stage[k-1].r_sat;
            assign w_x_in   = g_stage[k-1].r_x;
            assign w_y_in   = g_stage[k-1].r_y;
            assign w_s_in   = g_stage[k-1].r_s;
        end

        cla_group #(.G(GROUP)) u_grp (
            .iX    (w_x_in[k*GROUP +: GROUP]),
            .iY    (w_y_in[k*GROUP +: GROUP]),
            .iCin  (w_c_in),
            .oSum  (w_gsum),
            .oCout (w_gcout),
            .oCMsb (w_gcmsb)
        );

        always_comb begin
            w_sum                   = w_s_in;
            w_sum[k*GROUP +: GROUP] = w_gsum;
        end

        if (k == STAGES - 1) begin : g_flags
            logic   w_ovf;
            flags_t w_f;
            flags_t r_f;
            logic   w_unused;

            assign w_ovf = w_gcout ^ w_gcmsb;

            always_comb begin
                w_s_out = w_sum;
`ifdef PIPE_ADDER_SAT_EN
                if (w_sat_in && w_ovf) begin
                    w_s_out = (!w_x_in[WIDTH-1] && !w_y_in[WIDTH-1]) ?
                              {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
                end
`endif
                w_f.carry    = w_gcout;
                w_f.overflow = w_ovf;
                w_f.zero     = ~|w_s_out;
                w_f.negative = w_s_out[WIDTH-1];
            end

            always_ff @(posedge iClk or negedge iRst_n) begin
                if (!iRst_n) begin
                    r_f <= '0;
                end else if (w_adv) begin
                    r_f <= w_f;
                end
            end

            // Operand/carry copies in the last stage have no consumer.
            assign w_unused = ^{r_x, r_y, r_c, r_sat};
        end else begin : g_pass
            logic w_unused;
            assign w_s_out  = w_sum;
            assign w_unused = w_gcmsb;
        end

        always_ff @(posedge iClk or negedge iRst_n) begin
            if (!iRst_n) begin
                r_v   <= 1'b0;
                r_c   <= 1'b0;
                r_sat <= 1'b0;
                r_x   <= '0;
                r_y   <= '0;
                r_s   <= '0;
            end else if (w_adv) begin
                r_v   <= w_v_in;
                r_c   <= w_gcout;
                r_sat <= w_sat_in;
                r_x   <= w_x_in;
                r_y   <= w_y_in;
                r_s   <= w_s_out;
            end
        end
    end

    assign oValid    = g_stage[STAGES-1].r_v;
    assign oS        = g_stage[STAGES-1].r_s;
    assign oCarry    = g_stage[STAGES-1].g_flags.r_f.carry;
    assign oOverflow = g_stage[STAGES-1].g_flags.r_f.overflow;
    assign oZero     = g_stage[STAGES-1].g_flags.r_f.zero;
    assign oNegative = g_stage[STAGES-1].g_flags.r_f.negative;

endmodule
